spi_cmd_regs: RTL and testbench

Parametrised SPI command register block between the ESP-side SPI message decoder and the core. It decodes completed SPI messages into system control outputs: a timed reset pulse, keyboard matrix, hand controllers, and NUM_CFG generic configuration bytes. It adds a KBFIFO_DEPTH-deep keyboard character FIFO with multi-byte push and overflow tracking. It also returns status and configuration readback on spi_txdata.

---
 rtl/spi_cmd_regs_if.sv | 15 +
 rtl/spi_cmd_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_cmd_regs.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_regs_if.sv
// SPI message interface between the ESP-side message decoder and the command register block.
// Latency: no logic here. The master drives msg_end/cmd/rxdata and the slave returns txdata/txdata_valid.
// Backpressure: none. msg_end is a one-cycle strobe and the slave always accepts it.
// Ports: msg_end (message complete strobe), cmd (command byte), rxdata (payload, first byte at [63:56]),
//        txdata/txdata_valid (readback for the current cmd).
interface spi_cmd_regs_if;
  logic        msg_end;
  logic [7:0]  cmd;
  logic [63:0] rxdata;
  logic [63:0] txdata;
  logic        txdata_valid;

  modport master (output msg_end, cmd, rxdata, input txdata, txdata_valid);
  modport slave  (input msg_end, cmd, rxdata, output txdata, txdata_valid);
endinterface

// File: rtl/spi_cmd_regs.sv
// SPI command register block. It decodes completed messages into the reset pulse, keyboard matrix,
//   hand controller and config outputs, feeds a keyboard character FIFO, and returns status/config readback.
// Latency: register updates land 1 cycle after msg_end. FIFO pushes start at msg_end+2. Readback lags cmd by 1 cycle.
// Backpressure: none on the SPI side. A FIFO byte pushed while the FIFO is full is dropped, and so is a
//   WRITE_KBBUF message that arrives mid-push. Both drops set the sticky kbbuf_overflow flag.
// Ports: clk, reset (async, active-high), spi (slave side of spi_cmd_regs_if), o_reset_req/o_reset_req_cold,
//   o_keys, o_hctrl1/o_hctrl2, o_cfg (cfg[i] at [8i+7:8i]), o_kbbuf_data/o_kbbuf_empty/i_kbbuf_rden,
//   o_kbbuf_overflow.
module spi_cmd_regs #(
  parameter int NUM_CFG      = 4,
  parameter int KBFIFO_DEPTH = 16,
  parameter int RESET_PULSE  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  spi_cmd_regs_if.slave          spi,
  output logic                   o_reset_req,
  output logic                   o_reset_req_cold,
  output logic [63:0]            o_keys,
  output logic [7:0]             o_hctrl1,
  output logic [7:0]             o_hctrl2,
  output logic [8*NUM_CFG-1:0]   o_cfg,
  output logic [7:0]             o_kbbuf_data,
  output logic                   o_kbbuf_empty,
  input  logic                   i_kbbuf_rden,
  output logic                   o_kbbuf_overflow
);

  localparam int CW = $clog2(KBFIFO_DEPTH + 1);  // count: 0..DEPTH
  localparam int PW = $clog2(KBFIFO_DEPTH);      // pointers wrap naturally (power-of-two depth)
  localparam int RW = $clog2(RESET_PULSE + 1);

  localparam logic [7:0] CMD_RESET   = 8'h01;
  localparam logic [7:0] CMD_KEYB    = 8'h10;
  localparam logic [7:0] CMD_HCTRL   = 8'h11;
  localparam logic [7:0] CMD_KBWR    = 8'h12;
  localparam logic [7:0] CMD_KBSTAT  = 8'h13;
  localparam logic [7:0] CMD_SET_CFG = 8'h20;
  localparam logic [7:0] CMD_GET_CFG = 8'h21;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PUSH = 1'b1;

  // Command strobes, qualified by the end of the message.
  logic w_msg_reset, w_msg_keyb, w_msg_hctrl, w_msg_kbwr, w_msg_kbstat, w_msg_setcfg;
  assign w_msg_reset  = spi.msg_end && (spi.cmd == CMD_RESET);
  assign w_msg_keyb   = spi.msg_end && (spi.cmd == CMD_KEYB);
  assign w_msg_hctrl  = spi.msg_end && (spi.cmd == CMD_HCTRL);
  assign w_msg_kbwr   = spi.msg_end && (spi.cmd == CMD_KBWR);
  assign w_msg_kbstat = spi.msg_end && (spi.cmd == CMD_KBSTAT);
  assign w_msg_setcfg = spi.msg_end && (spi.cmd == CMD_SET_CFG);

  // ---------------- reset pulse ----------------
  logic [RW-1:0] r_rst_cnt;
  logic          r_rst_cold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_cnt  <= '0;
      r_rst_cold <= 1'b0;
    end else if (w_msg_reset) begin
      r_rst_cnt  <= RW'(RESET_PULSE);
      // A retrigger during a running pulse must not downgrade a cold request.
      r_rst_cold <= (r_rst_cnt != '0) ? (r_rst_cold | spi.rxdata[57]) : spi.rxdata[57];
    end else if (r_rst_cnt != '0) begin
      r_rst_cnt  <= r_rst_cnt - RW'(1);
    end
  end

  assign o_reset_req      = (r_rst_cnt != '0);
  assign o_reset_req_cold = r_rst_cold;

  // ---------------- keyboard matrix, hand controllers, config ----------------
  logic [63:0] r_keys;
  logic [7:0]  r_hctrl1, r_hctrl2;
  logic [7:0]  r_cfg [NUM_CFG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_keys   <= '1;
      r_hctrl1 <= 8'hFF;
      r_hctrl2 <= 8'hFF;
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= 8'h00;
    end else begin
      if (w_msg_keyb) r_keys <= spi.rxdata;
      if (w_msg_hctrl) begin
        r_hctrl2 <= spi.rxdata[63:56];
        r_hctrl1 <= spi.rxdata[55:48];
      end
      // An out-of-range index matches no entry and is ignored.
      if (w_msg_setcfg) begin
        for (int i = 0; i < NUM_CFG; i++)
          if (spi.rxdata[63:56] == 8'(i)) r_cfg[i] <= spi.rxdata[55:48];
      end
    end
  end

  assign o_keys   = r_keys;
  assign o_hctrl1 = r_hctrl1;
  assign o_hctrl2 = r_hctrl2;

  always_comb begin
    o_cfg = '0;
    for (int i = 0; i < NUM_CFG; i++) o_cfg[8*i +: 8] = r_cfg[i];
  end

  // ---------------- keyboard push FSM ----------------
  logic [0:0]  r_state;
  logic [2:0]  r_push_left;
  logic [55:0] r_payload;    // the next byte to push is always at [55:48]
  logic [2:0]  w_n;

  assign w_n = (spi.rxdata[63:56] > 8'd7) ? 3'd7 : spi.rxdata[58:56];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_push_left <= 3'd0;
      r_payload   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_msg_kbwr && (w_n != 3'd0)) begin
            r_state     <= ST_PUSH;
            r_push_left <= w_n;
            r_payload   <= spi.rxdata[55:0];
          end
        end
        ST_PUSH: begin
          r_payload   <= {r_payload[47:0], 8'h00};
          r_push_left <= r_push_left - 3'd1;
          if (r_push_left == 3'd1) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- keyboard FIFO ----------------
  logic [7:0]    r_mem [KBFIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_empty, r_overflow;
  logic          w_full, w_pop, w_push_req, w_push, w_push_drop, w_msg_drop;

  assign w_full      = (r_count == CW'(KBFIFO_DEPTH));
  assign w_pop       = i_kbbuf_rden && !r_empty;
  assign w_push_req  = (r_state == ST_PUSH);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && w_full && !w_pop;
  assign w_msg_drop  = w_msg_kbwr && (r_state == ST_PUSH);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      // Set has priority over the clear-on-read of the status command.
      if (w_push_drop || w_msg_drop) r_overflow <= 1'b1;
      else if (w_msg_kbstat)         r_overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_payload[55:48];
  end

  assign o_kbbuf_data     = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_kbbuf_empty    = r_empty;
  assign o_kbbuf_overflow = r_overflow;

  // ---------------- readback ----------------
  logic [8:0]  w_fill9;
  logic [7:0]  w_fill;
  logic [63:0] w_txdata, r_txdata;
  logic        w_txvld, r_txvld;

  assign w_fill9 = 9'(r_count);
  assign w_fill  = (w_fill9 > 9'd255) ? 8'hFF : w_fill9[7:0];

  always_comb begin
    w_txdata = '0;
    w_txvld  = 1'b0;
    case (spi.cmd)
      CMD_KBSTAT: begin
        w_txdata = {w_fill, r_overflow, 55'd0};
        w_txvld  = 1'b1;
      end
      CMD_GET_CFG: begin
        w_txvld = 1'b1;
        for (int i = 0; i < NUM_CFG; i++) w_txdata[63-8*i -: 8] = r_cfg[i];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txdata <= '0;
      r_txvld  <= 1'b0;
    end else begin
      r_txdata <= w_txdata;
      r_txvld  <= w_txvld;
    end
  end

  assign spi.txdata       = r_txdata;
  assign spi.txdata_valid = r_txvld;

endmodule

// File: tb/tb_spi_cmd_regs.sv
module tb_spi_cmd_regs;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rden = 1'b0;
  logic        rd_strobe = 1'b0;
  logic        reset_req, reset_req_cold, kb_empty, kb_ovf;
  logic [63:0] keys;
  logic [7:0]  hctrl1, hctrl2, kb_data;
  logic [31:0] cfg;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q_kb [$];   // expected keyboard bytes in pop order
  logic [63:0] q_rd [$];   // expected readback words

  spi_cmd_regs_if spi();

  spi_cmd_regs #(.NUM_CFG(4), .KBFIFO_DEPTH(16), .RESET_PULSE(8)) dut (
    .clk(clk), .reset(reset), .spi(spi),
    .o_reset_req(reset_req), .o_reset_req_cold(reset_req_cold),
    .o_keys(keys), .o_hctrl1(hctrl1), .o_hctrl2(hctrl2), .o_cfg(cfg),
    .o_kbbuf_data(kb_data), .o_kbbuf_empty(kb_empty), .i_kbbuf_rden(rden),
    .o_kbbuf_overflow(kb_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queues whenever the DUT presents a FIFO head being popped or a readback word.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rden && !kb_empty) begin
        checks++;
        if (q_kb.size() == 0) begin
          failures++;
          $display("FAIL kb_pop_unexpected actual=%h expected=none", kb_data);
        end else begin
          logic [7:0] e;
          e = q_kb.pop_front();
          checks--;
          chk("kb_pop_data", {56'd0, kb_data}, {56'd0, e});
        end
      end
      if (rd_strobe) begin
        checks++;
        if (!spi.txdata_valid || q_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_no_valid_or_unexpected valid=%b queued=%0d", spi.txdata_valid, q_rd.size());
          if (q_rd.size() != 0) void'(q_rd.pop_front());
        end else begin
          logic [63:0] e;
          e = q_rd.pop_front();
          checks--;
          chk("readback", spi.txdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] rx);
    tick();
    spi.cmd = c;
    spi.rxdata = rx;
    spi.msg_end = 1'b1;
    tick();
    spi.msg_end = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] c, input logic [63:0] exp);
    spi.cmd = c;
    tick();
    q_rd.push_back(exp);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic count_pulse(output int n);
    n = 0;
    while (reset_req && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rden = 1'b1;
    while (!kb_empty && guard < 40) begin
      guard++;
      tick();
    end
    rden = 1'b0;
    chk("drain_bounded", {63'd0, guard < 40}, 64'd1);
  endtask

  initial begin
    int n;
    spi.msg_end = 1'b0;
    spi.cmd = 8'h00;
    spi.rxdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_hctrl", {48'd0, hctrl2, hctrl1}, 64'hFFFF);
    chk("rst_cfg", {32'd0, cfg}, 64'd0);
    chk("rst_empty", {63'd0, kb_empty}, 64'd1);
    chk("rst_kbdata", {56'd0, kb_data}, 64'd0);
    chk("rst_ovf", {63'd0, kb_ovf}, 64'd0);
    chk("rst_req", {62'd0, reset_req, reset_req_cold}, 64'd0);
    chk("rst_tx", {spi.txdata[63:1], spi.txdata[0] | spi.txdata_valid}, 64'd0);

    // Cold reset pulse, retriggered in pulse cycle 5 with cold=0 (cold must stay set)
    send(8'h01, 64'h0200_0000_0000_0000);
    chk("pulse_start", {62'd0, reset_req, reset_req_cold}, 64'd3);
    repeat (3) tick();
    chk("pulse_cycle4", {63'd0, reset_req}, 64'd1);
    send(8'h01, 64'h0);
    chk("retrig_cold_kept", {63'd0, reset_req_cold}, 64'd1);
    count_pulse(n);
    chk("retrig_len", 64'(n), 64'd8);
    // Fresh warm reset overwrites cold
    send(8'h01, 64'h0);
    chk("warm_cold", {63'd0, reset_req_cold}, 64'd0);
    count_pulse(n);
    chk("warm_len", 64'(n), 64'd8);

    // Keyboard matrix, hand controllers, unknown command
    send(8'h10, 64'h0123_4567_89AB_CDEF);
    chk("keys", keys, 64'h0123_4567_89AB_CDEF);
    send(8'h11, 64'hA55A_FFFF_0000_0000);
    chk("hctrl", {48'd0, hctrl2, hctrl1}, 64'hA55A);
    send(8'h55, 64'h0);
    chk("unknown_ignored", keys, 64'h0123_4567_89AB_CDEF);
    spi.cmd = 8'h10;
    tick();
    tick();
    chk("tx_nonread", {spi.txdata[63:1], spi.txdata[0] | spi.txdata_valid}, 64'd0);

    // Three-byte push: head appears at msg_end+2
    send(8'h12, 64'h0341_4243_0000_0000);
    q_kb.push_back(8'h41); q_kb.push_back(8'h42); q_kb.push_back(8'h43);
    chk("push_empty_p1", {63'd0, kb_empty}, 64'd1);
    tick();
    chk("push_empty_p2", {63'd0, kb_empty}, 64'd0);
    chk("push_head_p2", {56'd0, kb_data}, 64'h41);
    drain();
    chk("drained_empty", {55'd0, kb_empty, kb_data}, 64'h100);

    // 7+7+7 bytes into a 16-deep FIFO
    send(8'h12, 64'h0701_0203_0405_0607);
    repeat (8) tick();
    send(8'h12, 64'h0711_1213_1415_1617);
    repeat (8) tick();
    send(8'h12, 64'h0721_2223_2425_2627);
    repeat (8) tick();
    for (int i = 1; i <= 7; i++) q_kb.push_back(8'(i));
    for (int i = 1; i <= 7; i++) q_kb.push_back(8'(8'h10 + i));
    q_kb.push_back(8'h21); q_kb.push_back(8'h22);
    chk("full_ovf", {63'd0, kb_ovf}, 64'd1);
    rd_check(8'h13, 64'h1080_0000_0000_0000);
    send(8'h13, 64'h0);
    chk("ovf_cleared", {63'd0, kb_ovf}, 64'd0);
    rd_check(8'h13, 64'h1000_0000_0000_0000);

    // Push and pop together while full: nothing dropped, count stays 16
    send(8'h12, 64'h0231_3200_0000_0000);
    q_kb.push_back(8'h31); q_kb.push_back(8'h32);
    rden = 1'b1;
    tick();
    tick();
    rden = 1'b0;
    rd_check(8'h13, 64'h1000_0000_0000_0000);
    drain();

    // WRITE_KBBUF arriving mid-push is dropped whole
    send(8'h12, 64'h0551_5253_5455_0000);
    send(8'h12, 64'h0261_6200_0000_0000);
    for (int i = 1; i <= 5; i++) q_kb.push_back(8'(8'h50 + i));
    repeat (6) tick();
    chk("midpush_ovf", {63'd0, kb_ovf}, 64'd1);
    rd_check(8'h13, 64'h0580_0000_0000_0000);
    drain();

    // Config registers: in-range, out-of-range, top index
    send(8'h20, 64'h025A_0000_0000_0000);
    send(8'h20, 64'h0711_0000_0000_0000);
    chk("cfg_a", {32'd0, cfg}, 64'h005A_0000);
    rd_check(8'h21, 64'h0000_5A00_0000_0000);
    send(8'h20, 64'h03C3_0000_0000_0000);
    chk("cfg_b", {32'd0, cfg}, 64'hC35A_0000);
    rd_check(8'h21, 64'h0000_5AC3_0000_0000);

    // Reset in the middle of a five-byte push
    spi.cmd = 8'h00;
    send(8'h12, 64'h0571_7273_7475_0000);
    tick();
    tick();
    chk("pre_reset_head", {55'd0, kb_empty, kb_data}, 64'h071);
    reset = 1'b1;
    #1;
    chk("reset_empty", {55'd0, kb_empty, kb_data}, 64'h100);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("post_reset_empty", {55'd0, kb_empty, kb_data}, 64'h100);
    chk("post_reset_ovf", {63'd0, kb_ovf}, 64'd0);
    chk("post_reset_cfg", {32'd0, cfg}, 64'd0);
    chk("post_reset_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);

    chk("kb_queue_left", 64'(q_kb.size()), 64'd0);
    chk("rd_queue_left", 64'(q_rd.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
